ro_freq_counter: RTL and testbench
==================================

# ro_freq_counter

Multi-channel ring-oscillator frequency counter that sits between the ring-oscillator worker taps and the chip's output mux. Each channel's asynchronous tap is synchronised, rising edges are counted over a programmable gate window of `clk` cycles, and per-channel results are latched for readout through a channel-select port. It supersedes single-channel tap observation with gated counting, saturation flags, continuous re-arming and abort.

## Interface
- `CHANNELS`, 4: number of ring-oscillator taps measured in parallel (1..8)
- `CNT_W`, 16: width of each edge counter and result
- `GATE_W`, 16: width of the gate-length input
- `SYNC_STAGES`, 2: flip-flop stages in each tap synchroniser (≥2)

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `ro_in`  in  CHANNELS  asynchronous ring-oscillator taps, pre-divided so tap frequency < clk/2
- `start`  in  1  request a measurement; sampled only in IDLE or DONE
- `stop`  in  1  abort the current gate; returns to IDLE, no `done`
- `cont`  in  1  continuous mode; sampled at gate end
- `gate_len`  in  GATE_W  gate length in clk cycles; sampled when `start` is accepted; 0 treated as 1
- `ch_sel`  in  clog2(CHANNELS) (min 1)  result channel to read
- `busy`  out  1  high while a gate is open
- `done`  out  1  one-cycle pulse when results are latched
- `count_out`  out  CNT_W  registered result of channel `ch_sel`
- `ovf_out`  out  1  registered saturation flag of channel `ch_sel`

## Operation
- States: IDLE, GATE, DONE. `rst` forces IDLE.
- IDLE/DONE, `start`=1: load the gate counter with max(gate_len,1), clear all live counters and their saturation bits, and go to GATE.
- DONE with `start`=0: go to IDLE after one cycle. `done` is high only in DONE.
- GATE: each cycle, decrement the gate counter. Each channel adds 1 when a rising edge is detected. On the final gate cycle, latch live counts and saturation bits into the result registers, then:
  - `cont`=1: reload `gate_len`, clear live counters, and stay in GATE. `done` pulses for one cycle and `busy` stays high.
  - `cont`=0: go to DONE.
- `stop` in GATE: go to IDLE next cycle. Result registers are untouched and `done` is not pulsed. `stop` has priority over gate end. `stop` outside GATE is ignored.
- `start` in GATE is ignored.
- Edge detect: `SYNC_STAGES` flip-flops, then one history flop. Edge = synced & ~history. The chain runs continuously, including in IDLE, so an already-high tap produces no edge at gate open.
- Counters saturate at 2^CNT_W−1 and set the channel's saturation bit. They never wrap.
- Readout: `count_out`/`ovf_out` are registered muxes of the result registers. They are updated every cycle irrespective of state.

## Timing
- Reset values: `busy`=0, `done`=0, `count_out`=0, `ovf_out`=0. All result registers, live counters, synchroniser and history flops are 0. State is IDLE.
- Gate start: `start` sampled high at edge T. `busy`=1 from T+1.
- Counting window: edges detected in cycles T+1..T+L (L = effective gate length) are counted.
- Gate end (cont=0): results valid in registers after edge T+L. `done`=1 during cycle T+L+1, `busy`=0 from T+L+1.
- Gate end (cont=1): `done` pulses during T+L+1 and the next window is T+L+1..T+2L, with no dead cycle.
- Tap latency: tap rising edge to counter increment is SYNC_STAGES+1 clk edges.
- Readout latency: `ch_sel` change or result latch to `count_out` is 1 cycle.
- `rst` mid-gate: next cycle is IDLE, all results cleared, no `done`.

## Test plan
- Reset: assert `rst` 2 cycles. All outputs are 0, `busy`=0, and every `ch_sel` reads 0.
- Basic count: ch0 toggled with period 4 clk, ch1 with period 8. `start` with gate_len=64. `done` pulses at T+65; ch0 reads 16±1, ch1 reads 8±1, `ovf_out`=0.
- Saturation: CNT_W=4, tap period 2, gate_len=100. Result = 15 and `ovf_out`=1.
- Continuous: `cont`=1, gate_len=10, tap period 5. `done` pulses every 10 cycles with `busy` stuck high; each result = 2±1. Drop `cont`: after the next `done`, `busy`=0.
- Abort: `stop` at gate cycle 5 of 64 after a prior result of 16. `busy` falls, no `done`, and the result still reads 16.
- Edge cases: gate_len=0 behaves as 1 (done at T+2). A tap held high before `start` counts 0. `start` during GATE is ignored.

Source files
------------

// File: rtl/ro_freq_counter.sv
`default_nettype none
// ============================================================================
// Module   : ro_freq_counter
// Purpose  : Multi-channel ring-oscillator frequency counter. Each tap is
//            synchronised and edge-detected continuously; rising edges are
//            counted over a programmable gate window of clk cycles and the
//            per-channel results are latched for readout via ch_sel.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            ro_in           - asynchronous taps (freq < clk/2)
//            start/stop/cont - measurement request / abort / continuous mode
//            gate_len        - window length in clk cycles (0 acts as 1)
//            ch_sel          - channel to present on count_out/ovf_out
//            busy, done      - gate open / one-cycle result-latched pulse
//            count_out       - registered result of the selected channel
//            ovf_out         - registered saturation flag of that channel
// Revision : 1.0 - initial release
// ============================================================================
module ro_freq_counter #(
  parameter  int CHANNELS    = 4,
  parameter  int CNT_W       = 16,
  parameter  int GATE_W      = 16,
  parameter  int SYNC_STAGES = 2,
  localparam int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] ro_in,
  input  logic                start,
  input  logic                stop,
  input  logic                cont,
  input  logic [GATE_W-1:0]   gate_len,
  input  logic [SEL_W-1:0]    ch_sel,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    count_out,
  output logic                ovf_out
);

  localparam logic [1:0]        S_IDLE   = 2'd0;
  localparam logic [1:0]        S_GATE   = 2'd1;
  localparam logic [1:0]        S_DONE   = 2'd2;
  localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [SEL_W:0]    CH_LIM   = (SEL_W+1)'(CHANNELS);

  logic [1:0]                                state_q, state_d;
  logic [GATE_W-1:0]                         gate_cnt_q, gate_cnt_d;
  logic [CHANNELS-1:0][SYNC_STAGES-1:0]      sync_q, sync_d;
  logic [CHANNELS-1:0]                       hist_q, hist_d;
  logic [CHANNELS-1:0][CNT_W-1:0]            cnt_q, cnt_d;
  logic [CHANNELS-1:0]                       sat_q, sat_d;
  logic [CHANNELS-1:0][CNT_W-1:0]            res_q, res_d;
  logic [CHANNELS-1:0]                       res_sat_q, res_sat_d;
  logic                                      done_q, done_d;
  logic [CNT_W-1:0]                          count_out_q, count_out_d;
  logic                                      ovf_out_q, ovf_out_d;

  logic                start_ok;
  logic                in_gate;
  logic                last_cycle;
  logic                gate_end;
  logic [GATE_W-1:0]   gate_eff;
  logic [CHANNELS-1:0] tap_edge;

  assign start_ok   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign in_gate    = (state_q == S_GATE);
  assign last_cycle = (gate_cnt_q == GATE_ONE);
  // stop wins over a coincident gate end: nothing is latched on abort.
  assign gate_end   = in_gate && !stop && last_cycle;
  assign gate_eff   = (gate_len == '0) ? GATE_ONE : gate_len;

  // Edge = last synchroniser stage high while the history flop is still low.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_edge
    assign tap_edge[g] = sync_q[g][SYNC_STAGES-1] & ~hist_q[g];
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_GATE;
      S_GATE: begin
        if (stop)                    state_d = S_IDLE;
        else if (last_cycle && !cont) state_d = S_DONE;
      end
      S_DONE: state_d = start ? S_GATE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_GATE);
    done      = done_q;
    count_out = count_out_q;
    ovf_out   = ovf_out_q;
  end

  // ----------------------------------------------------------- datapath
  always_comb begin
    gate_cnt_d = gate_cnt_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    res_d      = res_q;
    res_sat_d  = res_sat_q;
    done_d     = 1'b0;

    // Synchronisers run in every state so a tap already high at gate open
    // has long since been absorbed into the history flop.
    for (int c = 0; c < CHANNELS; c++) begin
      sync_d[c] = {sync_q[c][SYNC_STAGES-2:0], ro_in[c]};
      hist_d[c] = sync_q[c][SYNC_STAGES-1];
    end

    if (start_ok) begin
      gate_cnt_d = gate_eff;
      cnt_d      = '0;
      sat_d      = '0;
    end else if (in_gate) begin
      gate_cnt_d = gate_cnt_q - GATE_ONE;
      for (int c = 0; c < CHANNELS; c++) begin
        if (tap_edge[c]) begin
          if (cnt_q[c] == CNT_MAX) sat_d[c] = 1'b1;
          else                     cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
      // Latch includes the edge seen in the final window cycle.
      if (gate_end) begin
        res_d     = cnt_d;
        res_sat_d = sat_d;
        done_d    = 1'b1;
        if (cont) begin
          gate_cnt_d = gate_eff;
          cnt_d      = '0;
          sat_d      = '0;
        end
      end
    end
  end

  // Out-of-range selects (non power-of-two CHANNELS) read as zero.
  always_comb begin
    count_out_d = '0;
    ovf_out_d   = 1'b0;
    if ({1'b0, ch_sel} < CH_LIM) begin
      count_out_d = res_q[ch_sel];
      ovf_out_d   = res_sat_q[ch_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt_q  <= '0;
      sync_q      <= '0;
      hist_q      <= '0;
      cnt_q       <= '0;
      sat_q       <= '0;
      res_q       <= '0;
      res_sat_q   <= '0;
      done_q      <= 1'b0;
      count_out_q <= '0;
      ovf_out_q   <= 1'b0;
    end else begin
      gate_cnt_q  <= gate_cnt_d;
      sync_q      <= sync_d;
      hist_q      <= hist_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      res_q       <= res_d;
      res_sat_q   <= res_sat_d;
      done_q      <= done_d;
      count_out_q <= count_out_d;
      ovf_out_q   <= ovf_out_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ro_freq_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ro_freq_counter
// Purpose  : Scoreboard bench for ro_freq_counter. Two instances share all
//            inputs: a default one and a 4-bit-counter one whose results are
//            the saturated form of the default one's. Taps are generated
//            synchronously and periodically so every count is exact.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ro_freq_counter;

  typedef struct {
    bit [3:0] mask;
    int       exp [4];
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ro;
  logic        start, stop, cont;
  logic [15:0] gate_len;
  logic [1:0]  ch_sel;

  logic        busy_a, done_a, ovf_a;
  logic [15:0] count_a;
  logic        busy_b, done_b, ovf_b;
  logic [3:0]  count_b;

  int   per [4];
  bit   lvl [4];
  int   cyc;
  bit   chk_req;
  bit   rst_released;
  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb [$];

  ro_freq_counter u_dut_a (
    .clk(clk), .rst(rst), .ro_in(ro), .start(start), .stop(stop),
    .cont(cont), .gate_len(gate_len), .ch_sel(ch_sel),
    .busy(busy_a), .done(done_a), .count_out(count_a), .ovf_out(ovf_a)
  );

  ro_freq_counter #(.CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .ro_in(ro), .start(start), .stop(stop),
    .cont(cont), .gate_len(gate_len), .ch_sel(ch_sel),
    .busy(busy_b), .done(done_b), .count_out(count_b), .ovf_out(ovf_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Taps: periodic with one rising edge per period, or a static level.
  initial begin : tapgen
    cyc = 0;
    ro  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int c = 0; c < 4; c++)
        ro[c] = (per[c] != 0) ? ((cyc % per[c]) < (per[c] / 2)) : lvl[c];
    end
  end

  // Monitor: on each done (or an explicit readback request) pop one entry
  // and sweep the masked channels through ch_sel on both instances.
  initial begin : monitor
    exp_t e;
    int   eb;
    ch_sel = '0;
    wait (rst_released);
    for (int c = 0; c < 4; c++) begin
      ch_sel = 2'(c);
      @(negedge clk);
      chk("rst_count_a", count_a, 0);
      chk("rst_ovf_a",   ovf_a,   0);
      chk("rst_count_b", count_b, 0);
    end
    forever begin
      @(negedge clk);
      if (done_a || chk_req) begin
        if (done_a) chk("done_b_align", done_b, 1);
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_result_event: got a result event, expected none");
        end else begin
          e = sb.pop_front();
          for (int c = 0; c < 4; c++) begin
            if (e.mask[c]) begin
              ch_sel = 2'(c);
              @(negedge clk);
              eb = (e.exp[c] > 15) ? 15 : e.exp[c];
              chk($sformatf("count_a_ch%0d", c), count_a, e.exp[c]);
              chk($sformatf("ovf_a_ch%0d", c),   ovf_a,   0);
              chk($sformatf("count_b_ch%0d", c), count_b, eb);
              chk($sformatf("ovf_b_ch%0d", c),   ovf_b,   (e.exp[c] > 15) ? 1 : 0);
            end
          end
        end
      end
    end
  end

  task automatic push(input bit [3:0] m, input int e0, input int e1,
                      input int e2, input int e3);
    exp_t e;
    e.mask = m;
    e.exp  = '{e0, e1, e2, e3};
    sb.push_back(e);
  endtask

  // Start is sampled at edge T; returns early in cycle T+1.
  task automatic start_gate(input int len);
    @(negedge clk);
    start    = 1'b1;
    gate_len = 16'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // n counts negedges from the call; done during cycle T+L+1 gives n = L+1.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_a && n < 500);
    if (!done_a) begin
      n_total++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected done", n);
    end
  endtask

  initial begin : stim
    int n;
    int ndone;
    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0;
    gate_len = '0; chk_req = 1'b0; rst_released = 1'b0;
    per[0] = 4; per[1] = 8; per[2] = 0; per[3] = 0;
    lvl[0] = 0; lvl[1] = 0; lvl[2] = 1; lvl[3] = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_busy_b", busy_b, 0);
    rst_released = 1'b1;
    repeat (20) @(negedge clk);

    // Basic: period 4 -> 16, period 8 -> 8, held-high -> 0, low -> 0.
    push(4'b1111, 16, 8, 0, 0);
    start_gate(64);
    wait_done(n);
    chk("basic_done_latency", n, 65);
    chk("basic_busy_at_done", busy_a, 0);
    @(negedge clk);
    chk("basic_done_one_cycle", done_a, 0);
    repeat (8) @(negedge clk);

    // Abort at gate cycle 5: no done, previous result preserved.
    start_gate(64);
    repeat (5) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("abort_busy_fall", busy_a, 0);
    ndone = 0;
    repeat (80) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    push(4'b0001, 16, 0, 0, 0);
    @(posedge clk); #1 chk_req = 1'b1;
    @(posedge clk); #1 chk_req = 1'b0;
    repeat (8) @(negedge clk);

    // gate_len = 0 acts as a one-cycle window.
    push(4'b1100, 0, 0, 0, 0);
    start_gate(0);
    wait_done(n);
    chk("gate0_done_latency", n, 2);
    repeat (8) @(negedge clk);

    // start (with a different gate_len) during GATE is ignored.
    push(4'b0001, 16, 0, 0, 0);
    start_gate(64);
    repeat (9) @(negedge clk);
    start    = 1'b1;
    gate_len = 16'd20;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("start_in_gate_latency", n, 55);
    repeat (8) @(negedge clk);

    // Saturation: period 2 over 100 cycles = 50 edges; 4-bit instance pins at 15.
    per[0] = 2;
    repeat (20) @(negedge clk);
    push(4'b0001, 50, 0, 0, 0);
    start_gate(100);
    wait_done(n);
    chk("sat_done_latency", n, 101);
    repeat (8) @(negedge clk);

    // Continuous: period 5 over 10-cycle windows = 2 edges per window.
    per[0] = 5;
    cont   = 1'b1;
    repeat (20) @(negedge clk);
    repeat (4) push(4'b0001, 2, 0, 0, 0);
    start_gate(10);
    wait_done(n);
    chk("cont_first_latency", n, 11);
    chk("cont_busy_1", busy_a, 1);
    for (int k = 0; k < 2; k++) begin
      wait_done(n);
      chk("cont_period", n, 10);
      chk("cont_busy_held", busy_a, 1);
    end
    cont = 1'b0;
    wait_done(n);
    chk("cont_last_period", n, 10);
    chk("cont_busy_dropped", busy_a, 0);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
